// File: rtl/organ_voice_scheduler.sv
// organ_voice_scheduler: monophonic voice scheduler for the digital organ.
// Four note buttons are synchronized and debounced, then arbitrated onto a single
// programmable tone divider. The 2-bit octave select scales the half-period.
// Optional macro ORGAN_LAST_NOTE_EN selects last-note priority instead of
// fixed lowest-index priority.
module organ_voice_scheduler #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int GAP_CYCLES      = 1000,
    parameter int HALF_C          = 477,
    parameter int HALF_D          = 425,
    parameter int HALF_E          = 379,
    parameter int HALF_F          = 358,
    parameter int CNT_BITS        = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:4] button_n,
    input  logic [1:0] octaveSelect_n,
    output logic       tone,
    output logic       noteValid,
    output logic [1:0] activeNote
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    // Bit i of the button vectors is note i (0=C .. 3=F), stored as "pressed".
    logic [3:0]             btn_s1_q, btn_s2_q;
    logic [1:0]             oct_s1_q, oct_s2_q;
    logic [3:0]             db_q, db_d;
    logic [3:0][DB_W-1:0]   dbcnt_q, dbcnt_d;
    logic [1:0]             winner;

    state_t                 state_q, state_d;
    logic                   tone_q, tone_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [1:0]             active_q, active_d;
    logic [CNT_BITS-1:0]    half_win, half_act;

    function automatic logic [1:0] lowest(input logic [3:0] r);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) lowest = 2'(i);
        end
    endfunction

    // Octave value 3 is the highest octave and uses the base half-period unshifted.
    function automatic logic [CNT_BITS-1:0] half_for(input logic [1:0] note,
                                                     input logic [1:0] oct);
        logic [CNT_BITS-1:0] base;
        case (note)
            2'd0:    base = CNT_BITS'(HALF_C);
            2'd1:    base = CNT_BITS'(HALF_D);
            2'd2:    base = CNT_BITS'(HALF_E);
            default: base = CNT_BITS'(HALF_F);
        endcase
        half_for = base << (2'd3 - oct);
    endfunction

    // Two-flop synchronizers for buttons (inverted to pressed) and octave (inverted to 0..3).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            oct_s1_q <= '0;
            oct_s2_q <= '0;
        end else begin
            btn_s1_q <= ~{button_n[4], button_n[3], button_n[2], button_n[1]};
            btn_s2_q <= btn_s1_q;
            oct_s1_q <= ~octaveSelect_n;
            oct_s2_q <= oct_s1_q;
        end
    end

    // Stability counters: a level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_d    = db_q;
        dbcnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (btn_s2_q[i] != db_q[i]) begin
                if (dbcnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) db_d[i] = btn_s2_q[i];
                else dbcnt_d[i] = dbcnt_q[i] + 1'b1;
            end
        end
    end

    // Debounced button state and stability counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_q    <= '0;
            dbcnt_q <= '0;
        end else begin
            db_q    <= db_d;
            dbcnt_q <= dbcnt_d;
        end
    end

`ifdef ORGAN_LAST_NOTE_EN
    logic [1:0] last_q;
    logic [3:0] press_edge;
    assign press_edge = db_d & ~db_q;

    // Remember the most recently pressed note; simultaneous presses resolve to the lowest index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          last_q <= 2'd0;
        else if (|press_edge)  last_q <= lowest(press_edge);
    end

    // Last note wins while held; otherwise fall back to the lowest held note.
    assign winner = db_q[last_q] ? last_q : lowest(db_q);
`else
    assign winner = lowest(db_q);
`endif

    assign half_win = half_for(winner, oct_s2_q);
    assign half_act = half_for(active_q, oct_s2_q);

    // Scheduler FSM and tone divider next-state logic.
    always_comb begin
        state_d  = state_q;
        tone_d   = tone_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                tone_d = 1'b0;
                if (|db_q) begin
                    state_d  = PLAY;
                    tone_d   = 1'b1;
                    cnt_d    = half_win - 1'b1;
                    active_d = winner;
                end
            end
            PLAY: begin
                if (!(|db_q)) begin
                    state_d = IDLE;
                    tone_d  = 1'b0;
                    cnt_d   = '0;
                end else if (winner != active_q) begin
                    state_d = GAP;
                    tone_d  = 1'b0;
                    cnt_d   = '0;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    tone_d = ~tone_q;
                    cnt_d  = half_act - 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                tone_d = 1'b0;
                if (!(|db_q)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (gap_q == '0) begin
                    state_d  = PLAY;
                    tone_d   = 1'b1;
                    cnt_d    = half_win - 1'b1;
                    active_d = winner;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tone_d  = 1'b0;
            end
        endcase
    end

    // Scheduler state, divider and gap counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tone_q   <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
            active_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            tone_q   <= tone_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            active_q <= active_d;
        end
    end

    assign tone       = tone_q;
    assign noteValid  = (state_q == PLAY);
    assign activeNote = (state_q == PLAY) ? active_q : 2'd0;

endmodule

// File: tb/tb_organ_voice_scheduler.sv
// Directed bench for organ_voice_scheduler with DEBOUNCE_CYCLES=4, GAP_CYCLES=8.
module tb_organ_voice_scheduler;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:4] button_n;
    logic [1:0] octaveSelect_n;
    logic       tone;
    logic       noteValid;
    logic [1:0] activeNote;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int n;
    bit ok;
    bit seen;

    organ_voice_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .button_n      (button_n),
        .octaveSelect_n(octaveSelect_n),
        .tone          (tone),
        .noteValid     (noteValid),
        .activeNote    (activeNote)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Count consecutive negedge samples with tone at lvl (bounded).
    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (tone === lvl && len < 10000) begin
            len++;
            @(negedge clock);
        end
    endtask

    // Wait for noteValid to reach lvl within budget negedges.
    task automatic wait_nv(input logic lvl, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (noteValid === lvl) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    // Count consecutive negedge samples with noteValid low (bounded).
    task automatic gap_len(output int len);
        len = 0;
        while (noteValid === 1'b0 && len < 100) begin
            len++;
            @(negedge clock);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        button_n       = 4'b1111;
        octaveSelect_n = 2'b00;

        // 1: reset held while buttons toggle
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            button_n = 4'($urandom_range(0, 15));
            check("rst_tone", 32'(tone), 32'd0);
            check("rst_valid", 32'(noteValid), 32'd0);
            check("rst_note", 32'(activeNote), 32'd0);
        end
        button_n = 4'b1111;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("idle_valid", 32'(noteValid), 32'd0);
        check("idle_tone", 32'(tone), 32'd0);

        // 2: press C at octave 3; 2 sync + 4 debounce + 1 FSM edge
        button_n[1] = 1'b0;
        repeat (6) @(negedge clock);
        check("c_lat_before", 32'(noteValid), 32'd0);
        @(negedge clock);
        check("c_lat_valid", 32'(noteValid), 32'd1);
        check("c_note", 32'(activeNote), 32'd0);
        check("c_tone_start", 32'(tone), 32'd1);
        run_len(1'b1, n);
        check("c_high", n, 477);
        run_len(1'b0, n);
        check("c_low", n, 477);

        // 3: octave 0 takes effect from the next toggle
        octaveSelect_n = 2'b11;
        run_len(1'b1, n);
        check("oct_cur_high", n, 477);
        run_len(1'b0, n);
        check("oct0_low", n, 3816);
        run_len(1'b1, n);
        check("oct0_high", n, 3816);
        octaveSelect_n = 2'b00;
        button_n = 4'b1111;
        wait_nv(1'b0, 20, ok);
        check("c_release", 32'(ok), 32'd1);
        check("c_release_tone", 32'(tone), 32'd0);

        // 4: hold E, then add C -> gap of 8, C wins; release C -> gap, E again
        repeat (3) @(negedge clock);
        button_n[3] = 1'b0;
        wait_nv(1'b1, 20, ok);
        check("e_valid", 32'(ok), 32'd1);
        check("e_note", 32'(activeNote), 32'd2);
        run_len(1'b1, n);
        check("e_high", n, 379);
        button_n[1] = 1'b0;
        wait_nv(1'b0, 20, ok);
        check("ec_gap_enter", 32'(ok), 32'd1);
        check("ec_gap_tone", 32'(tone), 32'd0);
        check("ec_gap_note", 32'(activeNote), 32'd0);
        gap_len(n);
        check("ec_gap_len", n, 8);
        check("ec_c_note", 32'(activeNote), 32'd0);
        run_len(1'b1, n);
        check("ec_c_high", n, 477);
        button_n[1] = 1'b1;
        wait_nv(1'b0, 20, ok);
        check("ce_gap_enter", 32'(ok), 32'd1);
        gap_len(n);
        check("ce_gap_len", n, 8);
        check("ce_e_note", 32'(activeNote), 32'd2);
        run_len(1'b1, n);
        check("ce_e_high", n, 379);

        // Simultaneous D and F press: D wins immediately, no gap
        button_n = 4'b1111;
        wait_nv(1'b0, 20, ok);
        check("e_release", 32'(ok), 32'd1);
        repeat (3) @(negedge clock);
        button_n = 4'b1010;
        wait_nv(1'b1, 20, ok);
        check("df_valid", 32'(ok), 32'd1);
        check("df_note", 32'(activeNote), 32'd1);
        run_len(1'b1, n);
        check("df_high", n, 425);

        // 5: D bounce of 2 clocks never sounds
        button_n = 4'b1111;
        wait_nv(1'b0, 20, ok);
        check("df_release", 32'(ok), 32'd1);
        repeat (3) @(negedge clock);
        button_n[2] = 1'b0;
        repeat (2) @(negedge clock);
        button_n[2] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (noteValid !== 1'b0) seen = 1'b1;
        end
        check("bounce_silent", 32'(seen), 32'd0);

        // 6: release mid-high phase -> silent one clock after debounced release
        button_n[1] = 1'b0;
        wait_nv(1'b1, 20, ok);
        check("c2_valid", 32'(ok), 32'd1);
        repeat (10) @(negedge clock);
        button_n[1] = 1'b1;
        repeat (6) @(negedge clock);
        check("cut_before_tone", 32'(tone), 32'd1);
        check("cut_before_valid", 32'(noteValid), 32'd1);
        @(negedge clock);
        check("cut_tone", 32'(tone), 32'd0);
        check("cut_valid", 32'(noteValid), 32'd0);

        // Asynchronous reset mid-note silences without a clock edge
        repeat (3) @(negedge clock);
        button_n[1] = 1'b0;
        wait_nv(1'b1, 20, ok);
        check("c3_valid", 32'(ok), 32'd1);
        repeat (5) @(negedge clock);
        check("c3_tone_high", 32'(tone), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_tone", 32'(tone), 32'd0);
        check("arst_valid", 32'(noteValid), 32'd0);
        check("arst_note", 32'(activeNote), 32'd0);
        button_n = 4'b1111;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("post_rst_valid", 32'(noteValid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
